// File: rtl/booth_pkg.sv
// Shared types and constants for the radix-2 Booth sequential multiplier.
package booth_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StCalc,
      StDone
   } state_e;

   // Booth pair {Q[0], q_1}
   localparam logic [1:0] BOOTH_ADD = 2'b01;
   localparam logic [1:0] BOOTH_SUB = 2'b10;

   function automatic int unsigned cnt_width(input int unsigned width);
      return $clog2(width + 2);
   endfunction

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth iteration: add/subtract/none on A, then arithmetic shift of {A,Q,q_1}.
module booth_step
   import booth_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic [WIDTH+1:0] i_a,
   input  logic [WIDTH+1:0] i_m,
   input  logic [WIDTH:0]   i_q,
   input  logic             i_q_1,
   output logic [WIDTH+1:0] o_a,
   output logic [WIDTH:0]   o_q,
   output logic             o_q_1
);

   logic [WIDTH+1:0] w_sum;

   always_comb begin
      w_sum = i_a;
      case ({i_q[0], i_q_1})
         BOOTH_ADD: w_sum = i_a + i_m;
         BOOTH_SUB: w_sum = i_a - i_m;
         default:   w_sum = i_a;
      endcase
   end

   assign o_a   = {w_sum[WIDTH+1], w_sum[WIDTH+1:1]};
   assign o_q   = {w_sum[0], i_q[WIDTH:1]};
   assign o_q_1 = i_q[0];

endmodule

// File: rtl/booth_seq_multiplier.sv
// Radix-2 Booth sequential multiplier, WIDTH-bit operands with per-operand signedness,
// valid/ready handshakes on both sides and a synchronous abort.
module booth_seq_multiplier
   import booth_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned CNT_W = cnt_width(WIDTH)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   input  logic               a_signed,
   input  logic               b_signed,
   input  logic               abort,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] product
);

   localparam logic [CNT_W-1:0] StartCnt = CNT_W'(WIDTH + 1);
   localparam logic [CNT_W-1:0] LastCnt  = CNT_W'(1);

   state_e               r_state;
   logic [WIDTH+1:0]     r_a;
   logic [WIDTH+1:0]     r_m;
   logic [WIDTH:0]       r_q;
   logic                 r_q_1;
   logic [CNT_W-1:0]     r_count;
   logic                 r_in_ready;
   logic                 r_out_valid;
   logic [2*WIDTH-1:0]   r_product;

   logic [WIDTH+1:0]     w_next_a;
   logic [WIDTH:0]       w_next_q;
   logic                 w_next_q_1;

   booth_step #(
      .WIDTH (WIDTH)
   ) u_step (
      .i_a   (r_a),
      .i_m   (r_m),
      .i_q   (r_q),
      .i_q_1 (r_q_1),
      .o_a   (w_next_a),
      .o_q   (w_next_q),
      .o_q_1 (w_next_q_1)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= StIdle;
         r_a         <= '0;
         r_m         <= '0;
         r_q         <= '0;
         r_q_1       <= 1'b0;
         r_count     <= '0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_product   <= '0;
      end else begin
         case (r_state)
            StIdle: begin
               // abort wins over a simultaneous in_valid
               if (!abort && in_valid) begin
                  r_m        <= a_signed ? {{2{a[WIDTH-1]}}, a} : {2'b00, a};
                  r_q        <= {b_signed & b[WIDTH-1], b};
                  r_a        <= '0;
                  r_q_1      <= 1'b0;
                  r_count    <= StartCnt;
                  r_in_ready <= 1'b0;
                  r_state    <= StCalc;
               end
            end
            StCalc: begin
               if (abort) begin
                  r_in_ready <= 1'b1;
                  r_state    <= StIdle;
               end else begin
                  r_a     <= w_next_a;
                  r_q     <= w_next_q;
                  r_q_1   <= w_next_q_1;
                  r_count <= r_count - 1'b1;
                  if (r_count == LastCnt) begin
                     // Low 2*WIDTH bits of {A,Q} are exact for every mode combination
                     r_product   <= {w_next_a[WIDTH-2:0], w_next_q};
                     r_out_valid <= 1'b1;
                     r_state     <= StDone;
                  end
               end
            end
            StDone: begin
               if (abort || out_ready) begin
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_state     <= StIdle;
               end
            end
            default: begin
               r_out_valid <= 1'b0;
               r_in_ready  <= 1'b1;
               r_state     <= StIdle;
            end
         endcase
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign product   = r_product;

endmodule

// File: tb/tb_booth_seq_multiplier.sv
// Scoreboard bench for booth_seq_multiplier (WIDTH=8): directed edge cases then a random sweep.
module tb_booth_seq_multiplier;

   localparam int unsigned W = 8;

   logic           clk = 1'b0;
   logic           rst_n;
   logic           in_valid;
   logic           in_ready;
   logic [W-1:0]   a;
   logic [W-1:0]   b;
   logic           a_signed;
   logic           b_signed;
   logic           abort;
   logic           out_valid;
   logic           out_ready;
   logic [2*W-1:0] product;

   int             n_cmp  = 0;
   int             n_fail = 0;
   logic [2*W-1:0] exp_q[$];
   logic           rand_rdy = 1'b0;

   booth_seq_multiplier #(
      .WIDTH (W)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .a_signed  (a_signed),
      .b_signed  (b_signed),
      .abort     (abort),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .product   (product)
   );

   always #5 clk = ~clk;

   // Reference: plain integer multiply of the operands as the modes say they should be read
   function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y,
                                              input logic xs, input logic ys);
      longint vx;
      longint vy;
      longint p;
      if (xs) vx = longint'($signed(x));
      else    vx = longint'(x);
      if (ys) vy = longint'($signed(y));
      else    vy = longint'(y);
      p = vx * vy;
      return p[2*W-1:0];
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor: every delivered product is popped against the scoreboard
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n === 1'b1 && abort === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_fail++;
               $display("FAIL unexpected_output: got %h expected none", product);
            end else begin
               chk("product", 32'(product), 32'(exp_q.pop_front()));
            end
         end
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
      end
   end

   initial begin
      #5ms;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib,
                        input logic ias, input logic ibs);
      int  n;
      bit  acc;
      n   = 0;
      acc = 1'b0;
      a = ia; b = ib; a_signed = ias; b_signed = ibs;
      in_valid = 1'b1;
      while (!acc) begin
         @(negedge clk);
         if (in_ready && rst_n && !abort) begin
            exp_q.push_back(ref_mul(ia, ib, ias, ibs));
            acc = 1'b1;
         end
         tick();
         n++;
         if (!acc && n > 200) begin
            n_cmp++;
            n_fail++;
            $display("FAIL accept_timeout: got in_ready=%b expected 1", in_ready);
            acc = 1'b1;
         end
      end
      in_valid = 1'b0;
      a = W'($urandom); b = W'($urandom);
      a_signed = 1'($urandom); b_signed = 1'($urandom);
   endtask

   task automatic wait_valid();
      int n;
      n = 0;
      while (!out_valid && n < 50) begin
         tick();
         n++;
      end
      chk("wait_out_valid", 32'(out_valid), 32'd1);
   endtask

   task automatic release_out();
      out_ready = 1'b1;
      tick();
      chk("idle_after_deliver_ov", 32'(out_valid), 32'd0);
      chk("idle_after_deliver_ir", 32'(in_ready), 32'd1);
   endtask

   initial begin
      logic [2*W-1:0] held;
      bit             rose;
      int             n;
      logic [W-1:0]   ra;
      logic [W-1:0]   rb;

      rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0;
      a_signed = 1'b0; b_signed = 1'b0; abort = 1'b0; out_ready = 1'b0;
      repeat (3) tick();
      chk("reset_in_ready", 32'(in_ready), 32'd1);
      chk("reset_out_valid", 32'(out_valid), 32'd0);
      chk("reset_product", 32'(product), 32'd0);
      rst_n = 1'b1;
      tick();

      // min*min, exact latency, then backpressure
      issue(8'h80, 8'h80, 1'b1, 1'b1);
      for (int k = 1; k <= int'(W) + 1; k++) begin
         tick();
         if (k == int'(W)) chk("out_valid_early", 32'(out_valid), 32'd0);
      end
      chk("latency_out_valid", 32'(out_valid), 32'd1);
      chk("min_times_min", 32'(product), 32'h4000);
      held = product;
      for (int k = 0; k < 10; k++) begin
         tick();
         chk("bp_out_valid", 32'(out_valid), 32'd1);
         chk("bp_product", 32'(product), 32'(held));
         chk("bp_in_ready", 32'(in_ready), 32'd0);
      end
      release_out();

      out_ready = 1'b0;
      issue(8'hFF, 8'hFF, 1'b0, 1'b0);
      wait_valid();
      chk("uu_255x255", 32'(product), 32'hFE01);
      release_out();

      out_ready = 1'b0;
      issue(8'h80, 8'hFF, 1'b1, 1'b0);
      wait_valid();
      chk("su_m128x255", 32'(product), 32'h8080);
      release_out();

      // abort on the third CALC cycle
      out_ready = 1'b0;
      issue(8'd7, 8'd9, 1'b0, 1'b0);
      tick(); tick();
      abort = 1'b1;
      exp_q.delete();
      tick();
      abort = 1'b0;
      chk("abort_in_ready", 32'(in_ready), 32'd1);
      rose = 1'b0;
      for (int k = 0; k < 15; k++) begin
         if (out_valid) rose = 1'b1;
         tick();
      end
      chk("abort_no_out_valid", 32'(rose), 32'd0);

      out_ready = 1'b0;
      issue(8'd3, 8'hFB, 1'b1, 1'b1);
      wait_valid();
      chk("ss_3xm5", 32'(product), 32'hFFF1);
      release_out();

      // abort in IDLE blocks acceptance
      abort = 1'b1; in_valid = 1'b1; a = 8'd5; b = 8'd5;
      tick();
      abort = 1'b0; in_valid = 1'b0;
      chk("idle_abort_in_ready", 32'(in_ready), 32'd1);
      tick();
      chk("idle_abort_no_out", 32'(out_valid), 32'd0);

      // abort in DONE discards the result
      out_ready = 1'b0;
      issue(8'd11, 8'd13, 1'b0, 1'b0);
      wait_valid();
      abort = 1'b1;
      exp_q.delete();
      tick();
      abort = 1'b0;
      chk("done_abort_out_valid", 32'(out_valid), 32'd0);
      chk("done_abort_in_ready", 32'(in_ready), 32'd1);

      // reset mid-CALC with in_valid asserted
      issue(8'd200, 8'd100, 1'b0, 1'b0);
      tick(); tick(); tick();
      rst_n = 1'b0; in_valid = 1'b1;
      exp_q.delete();
      tick();
      chk("rst_calc_out_valid", 32'(out_valid), 32'd0);
      chk("rst_calc_in_ready", 32'(in_ready), 32'd1);
      chk("rst_calc_product", 32'(product), 32'd0);
      rst_n = 1'b1; in_valid = 1'b0;
      tick();
      chk("rst_calc_not_accepted", 32'(in_ready), 32'd1);

      // reset in DONE under backpressure
      issue(8'hF0, 8'h0F, 1'b0, 1'b0);
      wait_valid();
      chk("uu_240x15", 32'(product), 32'h0E10);
      rst_n = 1'b0;
      exp_q.delete();
      tick();
      rst_n = 1'b1;
      chk("rst_done_out_valid", 32'(out_valid), 32'd0);
      chk("rst_done_in_ready", 32'(in_ready), 32'd1);
      chk("rst_done_product", 32'(product), 32'd0);

      out_ready = 1'b0;
      issue(8'd0, 8'h81, 1'b1, 1'b1);
      wait_valid();
      chk("zero_operand", 32'(product), 32'd0);
      release_out();

      // Random sweep, all modes, random gaps and backpressure
      rand_rdy = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         repeat ($urandom_range(0, 2)) tick();
         case ($urandom_range(0, 5))
            0:       ra = 8'h80;
            1:       ra = 8'h00;
            2:       ra = 8'hFF;
            default: ra = W'($urandom);
         endcase
         case ($urandom_range(0, 5))
            0:       rb = 8'h80;
            1:       rb = 8'h7F;
            default: rb = W'($urandom);
         endcase
         issue(ra, rb, 1'($urandom), 1'($urandom));
      end
      n = 0;
      while ((exp_q.size() != 0 || !in_ready) && n < 200) begin
         tick();
         n++;
      end
      chk("drain_pending", 32'(exp_q.size()), 32'd0);
      rand_rdy = 1'b0;
      out_ready = 1'b1;
      repeat (5) tick();
      chk("final_idle_out_valid", 32'(out_valid), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/booth_seq_multiplier.md
Name: booth_seq_multiplier

Overview:
- Parametrised radix-2 Booth sequential multiplier; next generation of the team's fixed 4-bit shift-add Booth unit.
- Generalised to WIDTH-bit operands, with per-operand signed/unsigned mode.
- Valid/ready handshake on input and output, a synchronous abort, and one combined add-and-shift per cycle.
- Sits in the arithmetic datapath alongside the Wallace-tree and array multipliers as the area-optimised option.

Parameters:
WIDTH, 8, operand width in bits (>= 2)
CNT_W, $clog2(WIDTH+2), iteration counter width (derived; do not override)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  synchronous, active-low reset; sampled only on rising clk edge
in_valid  in  1  operand pair valid
in_ready  out  1  block can accept operands
a  in  WIDTH  multiplicand
b  in  WIDTH  multiplier
a_signed  in  1  1: a is two's complement; 0: unsigned
b_signed  in  1  1: b is two's complement; 0: unsigned
abort  in  1  synchronous cancel of any operation in flight
out_valid  out  1  product valid
out_ready  in  1  consumer accepts product
product  out  2*WIDTH  a*b; two's complement if either operand is signed, else unsigned

Behaviour:
- Reset (rst_n==0 at an edge):
  - state=IDLE; in_ready=1, out_valid=0, product=0.
  - All internal registers (A, Q, q_1, M, count) are cleared.
  - Reset overrides abort and all handshakes, including mid-operation.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready at an edge:
    - M := a extended to WIDTH+2 bits (sign-extend if a_signed, else zero-extend).
    - Q := b extended to WIDTH+1 bits (sign-extend if b_signed, else zero-extend).
    - A := 0, q_1 := 0, count := WIDTH+1; go to CALC.
  - Operands are latched; a/b/mode may change after acceptance.
- CALC:
  - in_ready=0.
  - Each cycle performs one Booth step on {Q[0],q_1}: 01 -> A+M; 10 -> A-M; 00/11 -> A unchanged.
  - The step result is then arithmetic-shifted right by 1 across {A,Q,q_1} in the same cycle.
  - count decrements each cycle; the step with count==1 is the last, and the next state is DONE.
- A width: A is WIDTH+2 bits (guard bit) so that A-M never overflows when M is the most negative value.
- Result width: the full result is {A,Q}, 2*WIDTH+3 bits; product is its low 2*WIDTH bits, which is exact for all mode combinations.
- Latency: the accept edge is E0; CALC occupies edges E1..E(WIDTH+1); out_valid=1 from after E(WIDTH+1). Latency is WIDTH+1 cycles after acceptance.
- DONE:
  - out_valid=1; product is stable and held while out_ready=0 (no limit).
  - On out_valid&&out_ready at an edge, go to IDLE; out_valid=0 next cycle.
  - product holds its last value until the next DONE.
- Throughput: one operation per WIDTH+3 cycles at best. in_ready is never asserted in DONE; no overlap of accept and deliver.
- abort:
  - In CALC or DONE: at the next edge go to IDLE, out_valid=0, and the result is discarded.
  - In IDLE: abort has priority over in_valid, so nothing is accepted that cycle.
- in_valid during CALC/DONE is ignored; the producer must hold it until in_ready.
- Edge operands:
  - Operand 0: the result is 0.
  - Signed min x signed min (WIDTH=4: -8*-8) gives +64; no overflow flag is needed.

Decomposition:
- booth_pkg:
  - state enum {IDLE, CALC, DONE}
  - Booth encoding constants (BOOTH_ADD=2'b01, BOOTH_SUB=2'b10)
  - function for counter width
- Sub-module booth_step (combinational):
  - inputs A, M, Q, q_1; outputs next {A,Q,q_1}
  - performs the add/sub/none selection and the arithmetic shift
  - instantiated once in the CALC datapath and unit-testable in isolation.

Test Plan:
- WIDTH=4, a=4'b1000 signed, b=4'b1000 signed, accept at E0 -> out_valid exactly after E5; product=8'h40 (+64).
- WIDTH=4, a=15 unsigned, b=15 unsigned -> product=8'hE1 (225); a=-8 signed, b=15 unsigned -> product=8'h88 (-120).
- Backpressure: out_ready=0 for 10 cycles after out_valid -> product and out_valid held stable, in_ready=0 throughout; out_ready=1 -> IDLE next cycle, in_ready=1.
- abort asserted on the 3rd CALC cycle -> IDLE next edge, out_valid never rises; the next op 3*(-5) signed gives product=8'hF1.
- rst_n=0 mid-CALC, and again in DONE with out_ready=0 -> next edge: out_valid=0, in_ready=1, product=0; simultaneous in_valid is ignored.
- WIDTH=8 randomised sweep of 10k ops, all four mode combinations, random in_valid/out_ready gaps -> every product matches the reference model; no lost or duplicated results.
